// File: rtl/eeg_sched_pkg.sv
// Shared definitions for the multi-channel EEG filter scheduler: FSM encoding,
// default sizing and packed-bus slicing helper.
package eeg_sched_pkg;

  localparam int N_CH_DEF = 8;
  localparam int DW_DEF   = 16;
  localparam int SW_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } sched_state_e;

  // LSB position of channel ch inside a packed bus of w-bit lanes.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/eeg_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel strictly after
// last_grant, wrapping around (last_grant itself has the lowest priority).
module eeg_rr_arbiter
  import eeg_sched_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int CHW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CHW-1:0]  last_grant_i,
  output logic [CHW-1:0]  grant_o,
  output logic            any_req_o
);

  logic [CHW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin
    grant_o   = '0;
    cand      = '0;
    any_req_o = |req_i;
    for (int i = N_CH; i >= 1; i--) begin
      cand = CHW'((int'(last_grant_i) + i) % N_CH);
      if (req_i[cand]) grant_o = cand;
    end
  end

endmodule

// File: rtl/eeg_filter_scheduler.sv
// Shares one stateless HP+LP filter-step datapath across N_CH channels: buffers
// one sample per channel, issues round-robin with saved state, writes state back.
module eeg_filter_scheduler
  import eeg_sched_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  parameter  int DW   = DW_DEF,
  parameter  int SW   = SW_DEF,
  localparam int CHW  = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    ch_valid,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic               state_clr,
  input  logic [N_CH-1:0]    ovr_clr,
  output logic [N_CH-1:0]    overrun,
  output logic               f_start,
  output logic [DW-1:0]      f_x,
  output logic [SW-1:0]      f_hp_z,
  output logic [SW-1:0]      f_lp_z,
  input  logic               f_done,
  input  logic [SW-1:0]      f_hp_next,
  input  logic [SW-1:0]      f_lp_next,
  input  logic [DW-1:0]      f_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHW-1:0]     out_ch,
  output logic [DW-1:0]      out_data,
  output logic               busy
);

  sched_state_e         state_q, state_d;
  logic [N_CH-1:0]      pending_q, pending_d;
  logic [N_CH-1:0]      overrun_q, overrun_d, ovr_set;
  logic signed [DW-1:0] hold_q [N_CH];
  logic signed [SW-1:0] hp_z_q [N_CH];
  logic signed [SW-1:0] lp_z_q [N_CH];
  logic [CHW-1:0]       last_grant_q, gch_q, arb_grant;
  logic                 arb_any, clr_req_q;
  logic                 clr_now, grant_now, wb_now, hs_now;
  logic                 f_start_q;
  logic signed [DW-1:0] gx_q;
  logic signed [SW-1:0] f_hp_z_q, f_lp_z_q;
  logic                 out_valid_q;
  logic [CHW-1:0]       out_ch_q;
  logic signed [DW-1:0] out_data_q;

  eeg_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i        (pending_q),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .any_req_o    (arb_any)
  );

  // A queued state clear blocks the grant for the IDLE cycle it executes in.
  always_comb begin
    clr_now   = (state_q == IDLE) && clr_req_q;
    grant_now = (state_q == IDLE) && !clr_req_q && arb_any;
    wb_now    = (state_q == WAIT) && f_done;
    hs_now    = (state_q == OUTPUT) && out_valid_q && out_ready;
    state_d   = state_q;
    unique case (state_q)
      IDLE:    if (grant_now) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (f_done) state_d = OUTPUT;
      OUTPUT:  if (hs_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sample arriving on the channel being granted is a fresh request, not an overrun.
  always_comb begin
    pending_d = pending_q;
    ovr_set   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_valid[i]) begin
        pending_d[i] = 1'b1;
        ovr_set[i]   = pending_q[i] && !(grant_now && (arb_grant == CHW'(i)));
      end else if (grant_now && (arb_grant == CHW'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    overrun_d = (overrun_q & ~ovr_clr) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      overrun_q    <= '0;
      last_grant_q <= CHW'(N_CH - 1);
      gch_q        <= '0;
      clr_req_q    <= 1'b0;
      f_start_q    <= 1'b0;
      gx_q         <= '0;
      f_hp_z_q     <= '0;
      f_lp_z_q     <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
        hp_z_q[i] <= '0;
        lp_z_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      clr_req_q <= state_clr || (clr_req_q && !clr_now);
      f_start_q <= grant_now;
      for (int i = 0; i < N_CH; i++) begin
        if (ch_valid[i]) hold_q[i] <= ch_data[ch_lsb(i, DW) +: DW];
      end
      // Operands are captured at grant and held until the next grant.
      if (grant_now) begin
        gch_q    <= arb_grant;
        gx_q     <= hold_q[arb_grant];
        f_hp_z_q <= hp_z_q[arb_grant];
        f_lp_z_q <= lp_z_q[arb_grant];
      end
      if (wb_now) begin
        hp_z_q[gch_q] <= f_hp_next;
        lp_z_q[gch_q] <= f_lp_next;
        out_data_q    <= f_y;
        out_ch_q      <= gch_q;
        out_valid_q   <= 1'b1;
      end
      if (clr_now) begin
        for (int i = 0; i < N_CH; i++) begin
          hp_z_q[i] <= '0;
          lp_z_q[i] <= '0;
        end
      end
      if (hs_now) begin
        out_valid_q  <= 1'b0;
        last_grant_q <= gch_q;
      end
    end
  end

  assign overrun   = overrun_q;
  assign f_start   = f_start_q;
  assign f_x       = gx_q;
  assign f_hp_z    = f_hp_z_q;
  assign f_lp_z    = f_lp_z_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_eeg_filter_scheduler.sv
// Directed bench for eeg_filter_scheduler with a one-cycle-latency datapath model
// (y = x ^ 0x0142, hp_next = hp_z + x, lp_next = lp_z + 0x10).
module tb_eeg_filter_scheduler;

  localparam int N_CH = 8;
  localparam int DW   = 16;
  localparam int SW   = 32;
  localparam int CHW  = $clog2(N_CH);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_CH-1:0]    ch_valid;
  logic [N_CH*DW-1:0] ch_data;
  logic               state_clr;
  logic [N_CH-1:0]    ovr_clr;
  logic [N_CH-1:0]    overrun;
  logic               f_start;
  logic [DW-1:0]      f_x;
  logic [SW-1:0]      f_hp_z;
  logic [SW-1:0]      f_lp_z;
  logic               f_done;
  logic [SW-1:0]      f_hp_next;
  logic [SW-1:0]      f_lp_next;
  logic [DW-1:0]      f_y;
  logic               out_valid;
  logic               out_ready;
  logic [CHW-1:0]     out_ch;
  logic [DW-1:0]      out_data;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  logic          dp_pend;
  logic [DW-1:0] dp_x;
  logic [SW-1:0] dp_hp, dp_lp;

  always #5 clk = ~clk;

  eeg_filter_scheduler #(.N_CH(N_CH), .DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .state_clr (state_clr),
    .ovr_clr   (ovr_clr),
    .overrun   (overrun),
    .f_start   (f_start),
    .f_x       (f_x),
    .f_hp_z    (f_hp_z),
    .f_lp_z    (f_lp_z),
    .f_done    (f_done),
    .f_hp_next (f_hp_next),
    .f_lp_next (f_lp_next),
    .f_y       (f_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Datapath model: f_done is high for the cycle after the f_start cycle.
  initial begin
    f_done = 1'b0; f_y = '0; f_hp_next = '0; f_lp_next = '0;
    dp_pend = 1'b0; dp_x = '0; dp_hp = '0; dp_lp = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        dp_pend = 1'b0;
        f_done  = 1'b0;
      end else begin
        f_done = dp_pend;
        if (dp_pend) begin
          f_y       = dp_x ^ 16'h0142;
          f_hp_next = dp_hp + {{(SW-DW){dp_x[DW-1]}}, dp_x};
          f_lp_next = dp_lp + 32'h10;
        end
        dp_pend = f_start;
        if (f_start) begin
          dp_x = f_x; dp_hp = f_hp_z; dp_lp = f_lp_z;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive_ch(input int ch, input logic [DW-1:0] d);
    ch_valid[ch]          = 1'b1;
    ch_data[ch*DW +: DW]  = d;
  endtask

  task automatic wait_fstart(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (f_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ch_valid = '0; state_clr = 1'b0; ovr_clr = '0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ch_valid = '0; ch_data = '0; state_clr = 1'b0; ovr_clr = '0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({f_start, out_valid, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: got start/valid/busy=%b want 000", {f_start, out_valid, busy});
    end
    checks++;
    if (overrun !== '0) begin
      failures++; $display("FAIL reset_overrun: got %h want 00", overrun);
    end
    checks++;
    if (f_x !== '0 || f_hp_z !== '0 || f_lp_z !== '0) begin
      failures++; $display("FAIL reset_operands: got x=%h hp=%h lp=%h want 0", f_x, f_hp_z, f_lp_z);
    end
    checks++;
    if (out_ch !== '0 || out_data !== '0) begin
      failures++; $display("FAIL reset_out: got ch=%0d data=%h want 0", out_ch, out_data);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || f_start !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got busy=%b start=%b want 0 0", busy, f_start);
    end
  endtask

  task automatic test_single;
    do_reset();
    drive_ch(2, 16'h0100); tick();
    ch_valid = '0; tick();
    checks++;
    if (f_start !== 1'b1 || f_x !== 16'h0100 || f_hp_z !== 32'h0 || f_lp_z !== 32'h0) begin
      failures++; $display("FAIL single_issue: got start=%b x=%h hp=%h lp=%h want 1 0100 0 0", f_start, f_x, f_hp_z, f_lp_z);
    end
    tick();
    checks++;
    if (f_start !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_pulse: got start=%b busy=%b want 0 1", f_start, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 16'h0042) begin
      failures++; $display("FAIL single_out: got v=%b ch=%0d data=%h want 1 2 0042", out_valid, out_ch, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    drive_ch(2, 16'h0020); tick();
    ch_valid = '0; tick();
    checks++;
    if (f_start !== 1'b1 || f_x !== 16'h0020 || f_hp_z !== 32'h100 || f_lp_z !== 32'h10) begin
      failures++; $display("FAIL single_state: got start=%b x=%h hp=%h lp=%h want 1 0020 100 10", f_start, f_x, f_hp_z, f_lp_z);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 16'h0162) begin
      failures++; $display("FAIL single_out2: got v=%b ch=%0d data=%h want 1 2 0162", out_valid, out_ch, out_data);
    end
    tick();
  endtask

  task automatic test_round_robin;
    int            cyc_seen [N_CH];
    logic [CHW-1:0] ch_seen [N_CH];
    logic [DW-1:0] dat_seen [N_CH];
    logic [DW-1:0] exp_dat [N_CH];
    int            n;
    exp_dat = '{16'h1142, 16'h1143, 16'h1140, 16'h1141, 16'h1146, 16'h1147, 16'h1144, 16'h1145};
    do_reset();
    for (int i = 0; i < N_CH; i++) drive_ch(i, 16'h1000 + 16'(i));
    tick();
    ch_valid = '0;
    n = 0;
    for (int c = 0; c < 60 && n < N_CH; c++) begin
      if (out_valid === 1'b1) begin
        cyc_seen[n] = c; ch_seen[n] = out_ch; dat_seen[n] = out_data; n++;
      end
      tick();
    end
    checks++;
    if (n != N_CH) begin
      failures++; $display("FAIL rr_count: got %0d results want %0d", n, N_CH);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ch_seen[i] !== 3'(i)) begin
        failures++; $display("FAIL rr_order[%0d]: got ch %0d want %0d", i, ch_seen[i], i);
      end
      checks++;
      if (dat_seen[i] !== exp_dat[i]) begin
        failures++; $display("FAIL rr_data[%0d]: got %h want %h", i, dat_seen[i], exp_dat[i]);
      end
      if (i > 0) begin
        checks++;
        if (cyc_seen[i] - cyc_seen[i-1] != 4) begin
          failures++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 4", i, cyc_seen[i] - cyc_seen[i-1]);
        end
      end
    end
    checks++;
    if (overrun !== '0) begin
      failures++; $display("FAIL rr_overrun: got %h want 00", overrun);
    end
    tick(); tick();
  endtask

  task automatic test_overrun;
    bit ok;
    do_reset();
    drive_ch(0, 16'h0001); tick();
    ch_valid = '0; drive_ch(5, 16'h0011); tick();
    drive_ch(5, 16'h0022); tick();
    ch_valid = '0;
    checks++;
    if (overrun !== 8'h20) begin
      failures++; $display("FAIL ovr_set: got %h want 20", overrun);
    end
    wait_fstart(10, ok);
    checks++;
    if (!ok || f_x !== 16'h0022 || f_hp_z !== 32'h0) begin
      failures++; $display("FAIL ovr_newest: got seen=%b x=%h hp=%h want 1 0022 0", ok, f_x, f_hp_z);
    end
    drive_ch(5, 16'h0033); tick();
    drive_ch(5, 16'h0044); ovr_clr = 8'h20; tick();
    ch_valid = '0; ovr_clr = '0;
    checks++;
    if (overrun !== 8'h20) begin
      failures++; $display("FAIL ovr_set_wins: got %h want 20", overrun);
    end
    ovr_clr = 8'h20; tick();
    ovr_clr = '0;
    checks++;
    if (overrun !== 8'h00) begin
      failures++; $display("FAIL ovr_clear: got %h want 00", overrun);
    end
    wait_fstart(10, ok);
    checks++;
    if (!ok || f_x !== 16'h0044 || f_hp_z !== 32'h22 || f_lp_z !== 32'h10) begin
      failures++; $display("FAIL ovr_reissue: got seen=%b x=%h hp=%h lp=%h want 1 0044 22 10", ok, f_x, f_hp_z, f_lp_z);
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    drive_ch(0, 16'h0005); tick();
    ch_valid = '0; drive_ch(3, 16'h0300); tick();
    ch_valid = '0; tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 16'h0147 || f_start !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d data=%h start=%b want 1 0 0147 0", i, out_valid, out_ch, out_data, f_start);
      end
      tick();
    end
    out_ready = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b0 || f_start !== 1'b0) begin
      failures++; $display("FAIL bp_release: got v=%b start=%b want 0 0", out_valid, f_start);
    end
    tick();
    checks++;
    if (f_start !== 1'b1 || f_x !== 16'h0300) begin
      failures++; $display("FAIL bp_next_grant: got start=%b x=%h want 1 0300", f_start, f_x);
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_state_clr;
    bit ok;
    do_reset();
    drive_ch(2, 16'h0100); tick();
    ch_valid = '0; tick(); tick();
    state_clr = 1'b1; tick();
    state_clr = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0042) begin
      failures++; $display("FAIL clr_writeback_out: got v=%b data=%h want 1 0042", out_valid, out_data);
    end
    drive_ch(1, 16'h0007); tick();
    ch_valid = '0; tick();
    checks++;
    if (f_start !== 1'b0) begin
      failures++; $display("FAIL clr_priority: got start=%b want 0", f_start);
    end
    tick();
    checks++;
    if (f_start !== 1'b1 || f_x !== 16'h0007 || f_hp_z !== 32'h0 || f_lp_z !== 32'h0) begin
      failures++; $display("FAIL clr_grant_after: got start=%b x=%h hp=%h lp=%h want 1 0007 0 0", f_start, f_x, f_hp_z, f_lp_z);
    end
    tick(); tick(); tick();
    drive_ch(2, 16'h0010); tick();
    ch_valid = '0;
    wait_fstart(10, ok);
    checks++;
    if (!ok || f_x !== 16'h0010 || f_hp_z !== 32'h0 || f_lp_z !== 32'h0) begin
      failures++; $display("FAIL clr_zeroed: got seen=%b x=%h hp=%h lp=%h want 1 0010 0 0", ok, f_x, f_hp_z, f_lp_z);
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    drive_ch(0, 16'h0777); tick();
    ch_valid = '0; drive_ch(1, 16'h0111); drive_ch(4, 16'h0444); tick();
    ch_valid = '0;
    checks++;
    if (f_start !== 1'b1 || f_x !== 16'h0777) begin
      failures++; $display("FAIL ar_issue: got start=%b x=%h want 1 0777", f_start, f_x);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || f_start !== 1'b0) begin
      failures++; $display("FAIL ar_in_wait: got busy=%b start=%b want 1 0", busy, f_start);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || f_start !== 1'b0 || out_valid !== 1'b0 || f_x !== '0 ||
        f_hp_z !== '0 || f_lp_z !== '0 || out_ch !== '0 || out_data !== '0 || overrun !== '0) begin
      failures++; $display("FAIL ar_immediate: got busy=%b start=%b v=%b x=%h hp=%h lp=%h ch=%0d data=%h ovr=%h want all 0",
                           busy, f_start, out_valid, f_x, f_hp_z, f_lp_z, out_ch, out_data, overrun);
    end
    tick();
    rst_n = 1'b1; tick();
    checks++;
    if (busy !== 1'b0 || f_start !== 1'b0) begin
      failures++; $display("FAIL ar_pending_lost: got busy=%b start=%b want 0 0", busy, f_start);
    end
    drive_ch(4, 16'h0abc); tick();
    ch_valid = '0; tick();
    checks++;
    if (f_start !== 1'b1 || f_x !== 16'h0abc) begin
      failures++; $display("FAIL ar_fresh_grant: got start=%b x=%h want 1 0abc", f_start, f_x);
    end
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overrun();
    test_backpressure();
    test_state_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeg_filter_scheduler.md
Name: eeg_filter_scheduler

Overview:
Time-multiplexes one stateless EEG filter-step datapath (HP+LP recursion) across N_CH acquisition channels. Buffers one pending sample per channel, picks channels round-robin, and sends each sample with that channel's saved filter state to the datapath. It writes the returned state back and presents the filtered result with a channel tag on a valid/ready output. Sits between the multi-channel ADC front end and the feature/classifier stage.

Parameters:
N_CH, 8, number of channels (2..16)
DW, 16, sample and result width (signed)
SW, 32, width of each filter state word (hp_z, lp_z)
CHW (localparam), $clog2(N_CH), channel index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_valid  in  N_CH  per-channel sample strobe, one-cycle
ch_data  in  N_CH*DW  packed samples; channel i at [i*DW +: DW]
state_clr  in  1  pulse: zero all channel filter state
ovr_clr  in  N_CH  write-1-to-clear mask for overrun flags
overrun  out  N_CH  sticky per-channel overrun flags
f_start  out  1  one-cycle datapath launch
f_x  out  DW  sample to datapath
f_hp_z  out  SW  saved HP state of granted channel
f_lp_z  out  SW  saved LP state of granted channel
f_done  in  1  datapath result valid, one-cycle
f_hp_next  in  SW  updated HP state
f_lp_next  in  SW  updated LP state
f_y  in  DW  filtered sample
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_ch  out  CHW  channel of result
out_data  out  DW  filtered result
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending, overrun, state memory, hold buffers all 0; last_grant=N_CH-1; f_start=0, out_valid=0, out_ch=0, out_data=0, f_x/f_hp_z/f_lp_z=0, busy=0, clr_req=0. Reset mid-operation aborts the transaction. Pending samples are lost.
- Capture: ch_valid[i] loads hold[i]<=ch_data[i] and sets pending[i]. If pending[i] is already set and not granted this cycle: newer data overwrites, overrun[i]<=1.
- Overrun: ovr_clr[i] clears overrun[i]. Set wins over clear in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE, clr_req=1: zero all state words in one cycle, clr_req<=0, no grant that cycle. This takes priority over grant.
- IDLE, any pending: grant the first pending channel searching upward from last_grant+1 with wrap. Latch gch and gx<=hold[gch]. Clear pending[gch]. Go to ISSUE.
- Grant and ch_valid on the same channel, same cycle: the granted sample is the old hold value. The new sample re-sets pending with no overrun.
- ISSUE: f_start=1 for exactly one cycle. f_x=gx; f_hp_z/f_lp_z = state[gch]. Operands stay stable until f_done. Go to WAIT.
- WAIT: on f_done, write state[gch]<=f_hp_next/f_lp_next and latch out_data<=f_y, out_ch<=gch. Set out_valid=1 and go to OUTPUT. f_done during ISSUE is ignored (earliest legal is the cycle after f_start).
- OUTPUT: hold out_valid/out_ch/out_data stable. On out_valid&&out_ready: out_valid<=0, last_grant<=gch, go to IDLE.
- Minimum latency, datapath latency 1: ch_valid at edge k, grant k+1, f_start visible k+1..k+2, f_done k+3, out_valid high after edge k+3. Per-sample service is at least 4 cycles plus backpressure.
- state_clr outside IDLE sets clr_req. The clear executes on the next IDLE cycle. The in-flight write-back completes first and is then zeroed.
- busy = (state != IDLE).

Decomposition:
- Package eeg_sched_pkg: FSM state encoding, N_CH/DW/SW defaults, helper function for packed channel slice.
- One sub-module: eeg_rr_arbiter (N_CH request vector, last_grant → grant index + any_req). It is purely combinational, rotate-and-priority-encode.
- Per-channel state storage is inline registers, not RAM, so the clear completes in one cycle.

Test Plan:
- Single channel: ch_valid[2] with ch_data=0x0100 → f_start with f_x=0x0100, f_hp_z=0, f_lp_z=0. Datapath model returns f_y=0x0042 → out_ch=2, out_data=0x0042. State[2] holds the returned values. The next ch2 sample is issued with those values.
- Round-robin: all 8 ch_valid pulse together, last_grant=7 → grant order 0,1,...,7. With out_ready=1 and latency 1, outputs are spaced 4 cycles apart. No overrun.
- Overrun: ch_valid[5] twice (data 0x0011 then 0x0022) while FSM is busy on ch0 → overrun[5]=1, ch5 is issued with 0x0022. ovr_clr[5] coincident with a third overrun → flag stays 1.
- Backpressure: out_ready=0 for 10 cycles in OUTPUT → out_valid, out_ch, out_data stable. No new f_start. A pending ch3 is granted only after the handshake.
- state_clr mid-WAIT → write-back occurs, then all state is zeroed on the first IDLE cycle. The next issue of any channel shows f_hp_z=f_lp_z=0.
- Async reset asserted in WAIT with pending on ch1/ch4 → all outputs 0 immediately, pending cleared. After release, a fresh ch_valid[4] is granted first.
